// File: rtl/adc_acq_pkg.sv
// Shared state encoding and trigger-mode constants for the ADC acquisition scheduler.
package adc_acq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_FLUSH     = 3'd1;
   localparam state_t ST_HOLDOFF   = 3'd2;
   localparam state_t ST_WAIT_TRIG = 3'd3;
   localparam state_t ST_CAPTURE   = 3'd4;
   localparam state_t ST_LATCH     = 3'd5;
   localparam state_t ST_READY     = 3'd6;

   localparam logic [1:0] MODE_AUTO   = 2'd0;
   localparam logic [1:0] MODE_NORMAL = 2'd1;
   localparam logic [1:0] MODE_SINGLE = 2'd2;

   // Mode 3 falls through to normal behaviour, so only auto and single need decoding.
   function automatic logic is_single(input logic [1:0] m);
      return m == MODE_SINGLE;
   endfunction

   function automatic logic is_auto(input logic [1:0] m);
      return m == MODE_AUTO;
   endfunction

endpackage

// File: rtl/adc_trig_edge.sv
// Registered edge detector on the comparator trigger level with polarity select.
module adc_trig_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic trig_i,
   input  logic edge_sel_i,
   output logic pulse_o
);

   logic trig_prev_d, trig_prev_q;

   // Previous level follows the input every cycle, independent of scheduler state.
   always_comb begin
      trig_prev_d = trig_i;
   end

   // Previous-level register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         trig_prev_q <= 1'b0;
      end else begin
         trig_prev_q <= trig_prev_d;
      end
   end

   // One-cycle pulse in the cycle the new level is first seen; 0 = rising, 1 = falling.
   always_comb begin
      if (edge_sel_i) begin
         pulse_o = ~trig_i & trig_prev_q;
      end else begin
         pulse_o = trig_i & ~trig_prev_q;
      end
   end

endmodule

// File: rtl/adc_acq_sched.sv
// Acquisition scheduler: flush, holdoff, trigger wait, frame capture and readout handoff.
module adc_acq_sched
   import adc_acq_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 3000,
   parameter int unsigned LEN_W     = 12,
   parameter int unsigned TIMEOUT   = 100000,
   parameter int unsigned FLUSH_CYC = 2,
   parameter int unsigned HOLD_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              edge_sel,
   input  logic [HOLD_W-1:0] holdoff,
   input  logic              trig_in,
   input  logic              arm,
   input  logic              abort,
   input  logic              frame_done,
   output logic              fifo_aclr,
   output logic              fifo_wrreq,
   output logic              frame_valid,
   output logic [LEN_W-1:0]  frame_len,
   output logic              forced,
   output logic [15:0]       frame_cnt,
   output logic              busy
);

   // One sequencing counter serves flush, holdoff and write phases; it must hold FRAME_LEN.
   localparam int unsigned SEQ_W = (HOLD_W > LEN_W) ? HOLD_W : LEN_W;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [SEQ_W-1:0] FLUSH_LAST = SEQ_W'(FLUSH_CYC - 1);
   localparam logic [SEQ_W-1:0] WRITE_LAST = SEQ_W'(FRAME_LEN - 1);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

   state_t             state_d, state_q;
   logic [SEQ_W-1:0]   seq_cnt_d, seq_cnt_q;
   logic [TMO_W-1:0]   tmo_cnt_d, tmo_cnt_q;
   logic [1:0]         mode_d, mode_q;
   logic               edge_sel_d, edge_sel_q;
   logic [HOLD_W-1:0]  holdoff_d, holdoff_q;
   logic [LEN_W-1:0]   frame_len_d, frame_len_q;
   logic [15:0]        frame_cnt_d, frame_cnt_q;
   logic               forced_d, forced_q;
   logic [SEQ_W-1:0]   hold_last;
   logic               trig_pulse;

   adc_trig_edge u_trig_edge (
      .clk_i      (clk),
      .rst_i      (rst),
      .trig_i     (trig_in),
      .edge_sel_i (edge_sel_q),
      .pulse_o    (trig_pulse)
   );

   // Holdoff of zero still spends one cycle in HOLDOFF.
   always_comb begin
      if (holdoff_q == '0) begin
         hold_last = '0;
      end else begin
         hold_last = SEQ_W'(holdoff_q - 1'b1);
      end
   end

   // Next-state and counter logic; abort overrides every transition.
   always_comb begin
      state_d     = state_q;
      seq_cnt_d   = seq_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      mode_d      = mode_q;
      edge_sel_d  = edge_sel_q;
      holdoff_d   = holdoff_q;
      frame_len_d = frame_len_q;
      frame_cnt_d = frame_cnt_q;
      forced_d    = forced_q;

      case (state_q)
         ST_IDLE: begin
            if (arm && !abort) begin
               state_d    = ST_FLUSH;
               seq_cnt_d  = '0;
               mode_d     = mode;
               edge_sel_d = edge_sel;
               holdoff_d  = holdoff;
            end
         end
         ST_FLUSH: begin
            forced_d = 1'b0;
            if (seq_cnt_q == FLUSH_LAST) begin
               state_d   = ST_HOLDOFF;
               seq_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (seq_cnt_q >= hold_last) begin
               state_d   = ST_WAIT_TRIG;
               seq_cnt_d = '0;
               tmo_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + 1'b1;
            end
         end
         ST_WAIT_TRIG: begin
            // A real edge takes priority over a coincident timeout.
            if (trig_pulse) begin
               state_d   = ST_CAPTURE;
               seq_cnt_d = '0;
            end else if (is_auto(mode_q) && tmo_cnt_q == TMO_LAST) begin
               state_d   = ST_CAPTURE;
               seq_cnt_d = '0;
               forced_d  = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            // Counter ends at FRAME_LEN, which LATCH copies into frame_len.
            seq_cnt_d = seq_cnt_q + 1'b1;
            if (seq_cnt_q == WRITE_LAST) begin
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            frame_len_d = seq_cnt_q[LEN_W-1:0];
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_READY;
         end
         ST_READY: begin
            if (frame_done) begin
               seq_cnt_d = '0;
               state_d   = is_single(mode_q) ? ST_IDLE : ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_d   = ST_IDLE;
         seq_cnt_d = '0;
         tmo_cnt_d = '0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         seq_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         mode_q      <= '0;
         edge_sel_q  <= 1'b0;
         holdoff_q   <= '0;
         frame_len_q <= '0;
         frame_cnt_q <= '0;
         forced_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         seq_cnt_q   <= seq_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         mode_q      <= mode_d;
         edge_sel_q  <= edge_sel_d;
         holdoff_q   <= holdoff_d;
         frame_len_q <= frame_len_d;
         frame_cnt_q <= frame_cnt_d;
         forced_q    <= forced_d;
      end
   end

   // Strobes decoded straight from the state register so they carry no extra latency.
   always_comb begin
      fifo_wrreq  = (state_q == ST_CAPTURE);
      fifo_aclr   = (state_q == ST_FLUSH);
      frame_valid = (state_q == ST_READY);
      busy        = (state_q != ST_IDLE);
      frame_len   = frame_len_q;
      frame_cnt   = frame_cnt_q;
      forced      = forced_q;
   end

endmodule

// File: tb/tb_adc_acq_sched.sv
// Scoreboard bench for adc_acq_sched: frame timing predicted from arm/done cycle arithmetic.
module tb_adc_acq_sched;
   import adc_acq_pkg::*;

   localparam int unsigned FL     = 16;
   localparam int unsigned TO     = 50;
   localparam int unsigned FC     = 2;
   localparam int unsigned LEN_W  = 12;
   localparam int unsigned HOLD_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        mode;
   logic              edge_sel;
   logic [HOLD_W-1:0] holdoff;
   logic              trig_in;
   logic              arm;
   logic              abort;
   logic              frame_done;
   logic              fifo_aclr;
   logic              fifo_wrreq;
   logic              frame_valid;
   logic [LEN_W-1:0]  frame_len;
   logic              forced;
   logic [15:0]       frame_cnt;
   logic              busy;

   adc_acq_sched #(
      .FRAME_LEN (FL),
      .LEN_W     (LEN_W),
      .TIMEOUT   (TO),
      .FLUSH_CYC (FC),
      .HOLD_W    (HOLD_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .edge_sel    (edge_sel),
      .holdoff     (holdoff),
      .trig_in     (trig_in),
      .arm         (arm),
      .abort       (abort),
      .frame_done  (frame_done),
      .fifo_aclr   (fifo_aclr),
      .fifo_wrreq  (fifo_wrreq),
      .frame_valid (frame_valid),
      .frame_len   (frame_len),
      .forced      (forced),
      .frame_cnt   (frame_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          start;
      int          len;
      bit          aborted;
      bit          forced;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] exp_cnt = 16'd0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: write bursts, flush pulses and frame_valid rises are matched to the scoreboard.
   int   wr_run = 0, wr_start = 0, aclr_run = 0;
   bit   pend = 0, prev_valid = 0;
   exp_t cur;

   always @(negedge clk) begin
      if (rst) begin
         wr_run = 0;
         aclr_run = 0;
         pend = 0;
         prev_valid = 0;
      end else begin
         if (fifo_wrreq) begin
            if (wr_run == 0) wr_start = cyc;
            wr_run++;
         end else if (wr_run != 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_burst", wr_run, 0);
            end else begin
               cur = exp_q.pop_front();
               check("burst_start", wr_start, cur.start);
               check("burst_len", wr_run, cur.len);
               pend = !cur.aborted;
            end
            wr_run = 0;
         end
         if (frame_valid && !prev_valid) begin
            if (!pend) begin
               check("unexpected_valid", 1, 0);
            end else begin
               check("valid_cycle", cyc, cur.start + FL + 1);
               check("frame_len", frame_len, FL);
               check("forced", forced, cur.forced);
               check("frame_cnt", frame_cnt, cur.cnt);
               pend = 0;
            end
         end
         prev_valid = frame_valid;
         if (fifo_aclr) begin
            aclr_run++;
         end else if (aclr_run != 0) begin
            check("aclr_len", aclr_run, FC);
            aclr_run = 0;
         end
      end
   end

   task automatic goto_cycle(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start from IDLE; afterwards scramble the config inputs, which must already be latched.
   task automatic arm_run(input logic [1:0] m, input bit es, input int h, output int s);
      step();
      mode = m;
      edge_sel = es;
      holdoff = HOLD_W'(h);
      trig_in = es;
      arm = 1'b1;
      s = cyc;
      step();
      arm = 1'b0;
      mode = 2'($urandom);
      edge_sel = 1'($urandom);
      holdoff = HOLD_W'($urandom);
   endtask

   // kind: 0 none, 1 edge at W+d, 2 active level set in HOLDOFF and held,
   // 3 opposite edge at W+k then selected edge at W+k+1+d.
   task automatic episode(input int s, input logic [1:0] m, input bit es, input int h,
                          input int kind, input int d, input int k, input bit do_abort);
      int   hp, w, t, cs;
      bit   f;
      exp_t e;
      hp = (h == 0) ? 1 : h;
      w  = s + 1 + FC + hp;
      case (kind)
         1:       t = w + d;
         3:       t = w + k + 1 + d;
         default: t = 1 << 30;
      endcase
      if (m == MODE_AUTO && t + 1 > w + TO) begin
         cs = w + TO;
         f  = 1'b1;
      end else begin
         cs = t + 1;
         f  = 1'b0;
      end
      e.start   = cs;
      e.forced  = f;
      e.aborted = do_abort;
      e.len     = do_abort ? 8 : FL;
      if (!do_abort) exp_cnt = exp_cnt + 16'd1;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      trig_in = es;
      if (kind == 2 || kind == 3) begin
         goto_cycle(s + 3);
         trig_in = !es;
      end
      if (kind == 3) begin
         goto_cycle(w + k);
         trig_in = es;
      end
      if (kind == 1 || kind == 3) begin
         goto_cycle(t);
         trig_in = !es;
      end
      if (do_abort) begin
         goto_cycle(cs + 7);
         abort = 1'b1;
         goto_cycle(cs + 8);
         abort = 1'b0;
         check("abort_busy", busy, 0);
         check("abort_wrreq", fifo_wrreq, 0);
         check("abort_valid", frame_valid, 0);
         check("abort_frame_cnt", frame_cnt, exp_cnt);
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (frame_valid !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      check("valid_seen", frame_valid, 1);
   endtask

   task automatic finish_frame(input bit with_abort, output int dcyc);
      wait_valid();
      repeat ($urandom_range(0, 3)) step();
      frame_done = 1'b1;
      abort = with_abort;
      dcyc = cyc;
      step();
      frame_done = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      int s, dn, nw;
      logic [1:0] m;
      bit es;
      int h, kind, d, k, sel;

      rst = 1'b1;
      mode = '0;
      edge_sel = 1'b0;
      holdoff = '0;
      trig_in = 1'b0;
      arm = 1'b0;
      abort = 1'b0;
      frame_done = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_valid", frame_valid, 0);
      check("rst_wrreq", fifo_wrreq, 0);
      check("rst_aclr", fifo_aclr, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      rst = 1'b0;
      step();

      // Normal mode: triggered frame, auto re-arm with wrong-edge first, then abort mid-capture.
      arm_run(MODE_NORMAL, 1'b0, 4, s);
      episode(s, MODE_NORMAL, 1'b0, 4, 1, 3, 0, 1'b0);
      finish_frame(1'b0, dn);
      episode(dn, MODE_NORMAL, 1'b0, 4, 3, 2, 1, 1'b0);
      finish_frame(1'b0, dn);
      episode(dn, MODE_NORMAL, 1'b0, 4, 1, 0, 0, 1'b1);
      arm_run(MODE_NORMAL, 1'b0, 2, s);
      episode(s, MODE_NORMAL, 1'b0, 2, 1, 1, 0, 1'b0);
      finish_frame(1'b1, dn);
      check("abort_done_busy", busy, 0);

      // Auto mode, falling edge: timeout, held level from holdoff, edge coinciding with timeout.
      arm_run(MODE_AUTO, 1'b1, 3, s);
      episode(s, MODE_AUTO, 1'b1, 3, 0, 0, 0, 1'b0);
      finish_frame(1'b0, dn);
      episode(dn, MODE_AUTO, 1'b1, 3, 2, 0, 0, 1'b0);
      finish_frame(1'b0, dn);
      episode(dn, MODE_AUTO, 1'b1, 3, 3, TO - 4, 2, 1'b0);
      finish_frame(1'b1, dn);
      check("auto_abort_busy", busy, 0);

      // Single mode: returns to IDLE and ignores triggers until the next arm.
      arm_run(MODE_SINGLE, 1'b0, 0, s);
      episode(s, MODE_SINGLE, 1'b0, 0, 1, 2, 0, 1'b0);
      finish_frame(1'b0, dn);
      check("single_idle_busy", busy, 0);
      trig_in = 1'b0;
      step();
      trig_in = 1'b1;
      nw = 0;
      repeat (10) begin
         step();
         if (fifo_wrreq) nw++;
      end
      check("single_no_wrreq", nw, 0);
      arm_run(MODE_SINGLE, 1'b1, 5, s);
      episode(s, MODE_SINGLE, 1'b1, 5, 3, 1, 0, 1'b0);
      finish_frame(1'b0, dn);
      check("single2_busy", busy, 0);

      // Randomized runs, each from IDLE and ended by frame_done (with abort when re-arming).
      for (int i = 0; i < 8; i++) begin
         m  = 2'($urandom_range(0, 3));
         es = 1'($urandom);
         h  = $urandom_range(0, 6);
         k  = $urandom_range(0, 3);
         if (m == MODE_AUTO) kind = $urandom_range(0, 3);
         else kind = ($urandom_range(0, 1) != 0) ? 1 : 3;
         sel = $urandom_range(0, 3);
         if (m == MODE_AUTO && kind == 1 && sel != 3) d = TO - 3 + sel;
         else d = $urandom_range(0, 8);
         arm_run(m, es, h, s);
         episode(s, m, es, h, kind, d, k, 1'b0);
         finish_frame(m != MODE_SINGLE, dn);
         check("rand_end_busy", busy, 0);
      end

      // frame_cnt wrap from 0xFFFF.
      step();
      force dut.frame_cnt_q = 16'hFFFF;
      step();
      release dut.frame_cnt_q;
      step();
      check("preload_cnt", frame_cnt, 16'hFFFF);
      exp_cnt = 16'hFFFF;
      arm_run(MODE_NORMAL, 1'b0, 1, s);
      episode(s, MODE_NORMAL, 1'b0, 1, 1, 1, 0, 1'b0);
      wait_valid();
      check("wrap_cnt", frame_cnt, 0);

      // Reset while READY together with frame_done.
      step();
      step();
      rst = 1'b1;
      frame_done = 1'b1;
      step();
      check("rst2_valid", frame_valid, 0);
      check("rst2_busy", busy, 0);
      check("rst2_aclr", fifo_aclr, 0);
      check("rst2_wrreq", fifo_wrreq, 0);
      check("rst2_len", frame_len, 0);
      check("rst2_forced", forced, 0);
      check("rst2_cnt", frame_cnt, 0);
      rst = 1'b0;
      frame_done = 1'b0;
      repeat (3) step();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case a run never completes.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d, required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adc_acq_sched.md
Name: adc_acq_sched

Overview:
- Acquisition scheduler for the ADC capture path. Sequences flush, holdoff, trigger wait, frame capture and readout handoff for the ADC sample FIFO.
- Runs in the ADC sample clock domain. Takes the level trigger from the hysteresis comparator and drives the FIFO write request and async clear.
- Presents a frame-ready/frame-done handshake toward the SPI readout side, with auto, normal and single trigger modes.

Parameters:
- FRAME_LEN, 3000: samples written per frame. Must be at most the FIFO depth.
- LEN_W, 12: width of the frame length and write counter.
- TIMEOUT, 100000: auto-mode cycles in WAIT_TRIG before a forced capture.
- FLUSH_CYC, 2: cycles fifo_aclr is held.
- HOLD_W, 16: width of the holdoff count.

Ports:
- clk  in  1  ADC sample clock
- rst  in  1  reset (see Behaviour)
- mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = treated as normal
- edge_sel  in  1  0 = rising edge of trig_in, 1 = falling edge
- holdoff  in  HOLD_W  cycles to wait after flush before triggers are accepted
- trig_in  in  1  comparator trigger level
- arm  in  1  start pulse; honoured only in IDLE
- abort  in  1  stop pulse
- frame_done  in  1  reader finished; honoured only in READY
- fifo_aclr  out  1  FIFO clear
- fifo_wrreq  out  1  FIFO write enable
- frame_valid  out  1  complete frame available in the FIFO
- frame_len  out  LEN_W  number of samples in the frame
- forced  out  1  current frame was captured by timeout
- frame_cnt  out  16  completed frames, wraps
- busy  out  1  state is not IDLE

Behaviour:
- Reset: synchronous, active-high; one clock, clk.
  - rst wins over every other input.
  - All outputs reset to 0. State resets to IDLE; all counters and trig_prev reset to 0.
- Decoding: fifo_wrreq = (state == CAPTURE), fifo_aclr = (state == FLUSH) and frame_valid = (state == READY), each decoded directly from the state register. busy = (state != IDLE).
- Configuration latch: mode, edge_sel and holdoff are captured on the arm that leaves IDLE. Changes made mid-run take effect on the next arm.
- Edge detect:
  - trig_prev <= trig_in every cycle, in all states.
  - Rising edge = trig_in & ~trig_prev; falling edge is the inverse.
  - Edges arriving before WAIT_TRIG are discarded.
- IDLE: arm -> FLUSH. frame_done and triggers are ignored.
- FLUSH: lasts FLUSH_CYC cycles -> HOLDOFF. forced <= 0.
- HOLDOFF: lasts max(holdoff, 1) cycles -> WAIT_TRIG. The timeout counter is cleared on exit.
- WAIT_TRIG:
  - A selected edge sampled in cycle n sets state = CAPTURE in cycle n+1; the first fifo_wrreq is in n+1.
  - In auto mode only, the timeout counter reaching TIMEOUT-1 with no edge -> CAPTURE and forced <= 1.
  - If an edge and the timeout coincide, the edge wins and forced stays 0.
- CAPTURE:
  - fifo_wrreq is high for exactly FRAME_LEN consecutive cycles; the write counter runs 0..FRAME_LEN-1.
  - On the last write -> LATCH. Triggers during CAPTURE are ignored.
- LATCH (1 cycle): frame_len <= write count (= FRAME_LEN) -> READY.
- READY:
  - frame_cnt increments on entry and wraps from 0xFFFF to 0.
  - frame_valid stays high until frame_done.
  - On frame_done: single mode -> IDLE; auto or normal -> FLUSH, which re-arms without a new arm.
- abort: from any state, the next state is IDLE and all counters clear. frame_len, frame_cnt and forced hold their values.
- Simultaneous events:
  - abort together with frame_done -> IDLE.
  - abort together with arm in IDLE -> IDLE.
  - frame_done outside READY is ignored.
  - arm outside IDLE is ignored.

Decomposition:
- Package adc_acq_pkg holds:
  - state enum: IDLE, FLUSH, HOLDOFF, WAIT_TRIG, CAPTURE, LATCH, READY
  - mode constants: MODE_AUTO, MODE_NORMAL, MODE_SINGLE
- One sub-module, adc_trig_edge: registered edge detector with polarity select and a one-cycle pulse output.

Test Plan:
- Normal mode, holdoff=4, FRAME_LEN=16 (bench override), rising edge of trig_in at cycle T in WAIT_TRIG -> fifo_wrreq high T+1..T+16, frame_valid at T+18, frame_len=16, frame_cnt=1, forced=0.
- Auto mode, TIMEOUT=50, no trigger -> CAPTURE entered 50 cycles after WAIT_TRIG entry, forced=1. Then frame_done -> fifo_aclr high for 2 cycles, and the cycle repeats without arm.
- Single mode: after frame_done -> IDLE, busy=0. A further trig_in edge gives no fifo_wrreq. Pulsing arm restarts the sequence.
- edge_sel=1: a rising edge is ignored and a falling edge starts capture. An edge applied during HOLDOFF and held is never captured.
- abort in the middle of CAPTURE (8 of 16 writes done) -> fifo_wrreq drops next cycle, state IDLE, frame_valid=0, frame_cnt unchanged. The next arm produces a fresh 16-sample frame after flush.
- rst asserted in READY together with frame_done -> all outputs 0 next cycle. frame_cnt wraps 0xFFFF -> 0 (preload via force).
